// File: rtl/fb_pixel_sink.sv
// Pixel sink between the line drawer and the VGA framebuffer write port.
// It drops out-of-range and repeated pixels, buffers the rest in a small FIFO, and sweeps the screen on a clear.
module fb_pixel_sink #(
  parameter int                 H_RES      = 160,
  parameter int                 V_RES      = 120,
  parameter int                 ADDR_W     = 15,
  parameter int                 COLOR_W    = 3,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [COLOR_W-1:0] BG_COLOR   = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_i,
  input  logic [8:0]         x_i,
  input  logic [8:0]         y_i,
  input  logic [COLOR_W-1:0] color_i,
  input  logic               clear_i,
  input  logic               fb_grant_i,
  output logic               fb_we_o,
  output logic [ADDR_W-1:0]  fb_addr_o,
  output logic [COLOR_W-1:0] fb_data_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic [15:0]        drop_cnt_o,
  output logic [1:0]         dbg_state_o
);
  // Handshake: a pixel is taken on any rising edge where wr_i and ready_o are both high;
  // a framebuffer write is issued for the cycle after an edge where fb_grant_i was high and data was pending.

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, CLEAR = 2'd2} state_t;

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = ADDR_W + COLOR_W;
  localparam int KEY_W   = 18 + COLOR_W;
  localparam int NPIX    = H_RES * V_RES;

  state_t               r_state, w_state_nxt;
  logic [ENTRY_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wptr, r_rptr;
  logic [CNT_W-1:0]     r_count;
  logic [ADDR_W-1:0]    r_sweep;
  logic                 r_last_vld;
  logic [KEY_W-1:0]     r_last;
  logic [15:0]          r_drop;
  logic                 r_we;
  logic [ADDR_W-1:0]    r_addr;
  logic [COLOR_W-1:0]   r_data;

  logic [ADDR_W-1:0]    w_x, w_y, w_addr;
  logic                 w_ready, w_in_range, w_dup, w_push, w_drop, w_pop;
  logic                 w_sweep_wr, w_sweep_last, w_enter_drain;

  assign w_x = ADDR_W'(x_i);
  assign w_y = ADDR_W'(y_i);

  generate
    if (H_RES == 160) begin : g_addr_shift
      assign w_addr = (w_y << 7) + (w_y << 5) + w_x;
    end else begin : g_addr_mul
      assign w_addr = w_y * ADDR_W'(H_RES) + w_x;
    end
  endgenerate

  assign w_ready      = (r_state == RUN) && (r_count < CNT_W'(FIFO_DEPTH));
  assign w_in_range   = (32'(x_i) < 32'(H_RES)) && (32'(y_i) < 32'(V_RES));
  assign w_dup        = r_last_vld && (r_last == {x_i, y_i, color_i});
  assign w_push       = wr_i && w_ready && w_in_range && !w_dup;
  assign w_drop       = wr_i && !w_dup && (!w_ready || !w_in_range);
  assign w_pop        = (r_count != '0) && fb_grant_i;
  assign w_sweep_wr   = (r_state == CLEAR) && fb_grant_i;
  assign w_sweep_last = (r_sweep == ADDR_W'(NPIX - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_enter_drain = 1'b0;
    case (r_state)
      RUN: begin
        if (clear_i) begin
          w_state_nxt   = DRAIN;
          w_enter_drain = 1'b1;
        end
      end
      DRAIN: begin
        if (r_count == '0) w_state_nxt = CLEAR;
      end
      CLEAR: begin
        if (w_sweep_wr && w_sweep_last) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= RUN;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_sweep    <= '0;
      r_last_vld <= 1'b0;
      r_last     <= '0;
      r_drop     <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // The dup flag only survives an unbroken strobe and never crosses a clear.
      if (w_enter_drain || !wr_i) begin
        r_last_vld <= 1'b0;
      end else if (w_push) begin
        r_last_vld <= 1'b1;
        r_last     <= {x_i, y_i, color_i};
      end

      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;

      if (r_state == DRAIN)  r_sweep <= '0;
      else if (w_sweep_wr)   r_sweep <= r_sweep + 1'b1;

      if (w_pop) begin
        r_we             <= 1'b1;
        {r_addr, r_data} <= r_mem[r_rptr];
      end else if (w_sweep_wr) begin
        r_we   <= 1'b1;
        r_addr <= r_sweep;
        r_data <= BG_COLOR;
      end else begin
        r_we <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {w_addr, color_i};
  end

  assign fb_we_o     = r_we;
  assign fb_addr_o   = r_addr;
  assign fb_data_o   = r_data;
  assign ready_o     = w_ready;
  assign busy_o      = (r_state != RUN);
  assign drop_cnt_o  = r_drop;
  assign dbg_state_o = r_state;
endmodule

// File: tb/tb_fb_pixel_sink.sv
// Directed bench for fb_pixel_sink: expected framebuffer writes are queued by the stimulus
// and popped by an independent write monitor; status outputs are checked inline.
module tb_fb_pixel_sink;
  localparam int ADDR_W  = 15;
  localparam int COLOR_W = 3;
  localparam int W       = ADDR_W + COLOR_W;

  logic               clk = 1'b0;
  logic               reset;
  logic               wr_i;
  logic [8:0]         x_i, y_i;
  logic [COLOR_W-1:0] color_i;
  logic               clear_i;
  logic               fb_grant_i;
  logic               fb_we_o;
  logic [ADDR_W-1:0]  fb_addr_o;
  logic [COLOR_W-1:0] fb_data_o;
  logic               ready_o;
  logic               busy_o;
  logic [15:0]        drop_cnt_o;
  logic [1:0]         dbg_state_o;

  logic [W-1:0] exp_q[$];
  int           n_pass = 0;
  int           n_total = 0;
  int           n_writes = 0;
  logic         g_prev = 1'b0;

  fb_pixel_sink dut (
    .clk        (clk),
    .reset      (reset),
    .wr_i       (wr_i),
    .x_i        (x_i),
    .y_i        (y_i),
    .color_i    (color_i),
    .clear_i    (clear_i),
    .fb_grant_i (fb_grant_i),
    .fb_we_o    (fb_we_o),
    .fb_addr_o  (fb_addr_o),
    .fb_data_o  (fb_data_o),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .drop_cnt_o (drop_cnt_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // drivers and checkers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  task automatic set_pix(input int x, input int y, input int c);
    wr_i    = 1'b1;
    x_i     = 9'(x);
    y_i     = 9'(y);
    color_i = COLOR_W'(c);
  endtask

  task automatic idle(input int n);
    wr_i = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_wr(input int addr, input int data);
    exp_q.push_back({ADDR_W'(addr), COLOR_W'(data)});
  endtask

  // scoreboard monitor
  always @(posedge clk) g_prev <= fb_grant_i;

  always @(negedge clk) begin
    if (reset === 1'b1 && fb_we_o === 1'b1) begin
      n_writes++;
      check("grant_before_write", {31'd0, g_prev}, 32'd1);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got addr %0d data %0d expected no write", fb_addr_o, fb_data_o);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("write_addr_data", 32'({fb_addr_o, fb_data_o}), 32'(e));
      end
    end
  end

  initial begin
    int base;
    int cyc;
    reset = 1'b0; wr_i = 1'b0; x_i = '0; y_i = '0; color_i = '0;
    clear_i = 1'b0; fb_grant_i = 1'b1;
    repeat (3) tick();
    check("rst_we",    32'(fb_we_o), 0);
    check("rst_addr",  32'(fb_addr_o), 0);
    check("rst_data",  32'(fb_data_o), 0);
    check("rst_drop",  32'(drop_cnt_o), 0);
    check("rst_busy",  32'(busy_o), 0);
    check("rst_ready", 32'(ready_o), 1);
    check("rst_state", 32'(dbg_state_o), 0);
    reset = 1'b1;
    tick();

    // single pixel, two-cycle latency, no bypass
    set_pix(3, 2, 5);
    expect_wr(323, 5);
    tick();
    wr_i = 1'b0;
    check("no_bypass", 32'(fb_we_o), 0);
    tick();
    check("latency_we", 32'(fb_we_o), 1);
    idle(3);
    check("drop_after_single", 32'(drop_cnt_o), 0);

    // held strobe collapses to one write; a gap re-arms it
    set_pix(80, 60, 7);
    expect_wr(9680, 7);
    repeat (10) tick();
    wr_i = 1'b0;
    tick();
    set_pix(80, 60, 7);
    expect_wr(9680, 7);
    tick();
    idle(4);
    check("drop_after_dup", 32'(drop_cnt_o), 0);

    // overflow with grant low, then burst drain
    fb_grant_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_pix(i + 1, 1, i + 1);
      if (i < 4) expect_wr(161 + i, i + 1);
      tick();
      if (i == 2) check("ready_at_3", 32'(ready_o), 1);
      if (i == 3) check("ready_full", 32'(ready_o), 0);
    end
    idle(1);
    check("drop_overflow", 32'(drop_cnt_o), 2);
    check("stall_no_we", 32'(fb_we_o), 0);
    fb_grant_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("burst_we", 32'(fb_we_o), 1);
    end
    tick();
    check("burst_end", 32'(fb_we_o), 0);
    check("ready_after_burst", 32'(ready_o), 1);

    // range limits
    set_pix(160, 0, 1);
    tick();
    check("drop_x_range", 32'(drop_cnt_o), 3);
    set_pix(0, 120, 1);
    tick();
    check("drop_y_range", 32'(drop_cnt_o), 4);
    set_pix(159, 119, 3);
    expect_wr(19199, 3);
    tick();
    idle(4);

    // clear with two queued pixels and toggling grant
    fb_grant_i = 1'b0;
    set_pix(10, 10, 1); expect_wr(1610, 1); tick();
    set_pix(11, 10, 2); expect_wr(1611, 2); tick();
    wr_i = 1'b0;
    for (int a = 0; a < 19200; a++) expect_wr(a, 0);
    base = n_writes;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clear_busy", 32'(busy_o), 1);
    check("clear_not_ready", 32'(ready_o), 0);
    cyc = 0;
    while (busy_o && cyc < 50000) begin
      fb_grant_i = ~fb_grant_i;
      if (cyc >= 200 && cyc < 205) set_pix(1, 2, 3);
      else wr_i = 1'b0;
      if (cyc == 202) begin
        check("sweep_busy", 32'(busy_o), 1);
        check("sweep_not_ready", 32'(ready_o), 0);
      end
      tick();
      cyc++;
    end
    if (busy_o) begin
      n_total++;
      $display("FAIL clear_timeout: busy still %0d after %0d cycles, expected 0", busy_o, cyc);
    end
    check("clear_last_we", 32'(fb_we_o), 1);
    check("clear_last_addr", 32'(fb_addr_o), 19199);
    check("clear_ready_back", 32'(ready_o), 1);
    fb_grant_i = 1'b1;
    idle(2);
    check("clear_write_count", 32'(n_writes - base), 19202);
    check("clear_drops", 32'(drop_cnt_o), 9);
    check("clear_queue_empty", 32'(exp_q.size()), 0);

    // reset in the middle of a sweep
    for (int a = 0; a < 100; a++) expect_wr(a, 0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    cyc = 0;
    while (!(fb_we_o && fb_addr_o == 15'd99) && cyc < 1000) begin
      tick();
      cyc++;
    end
    check("sweep_reached_99", 32'(fb_addr_o), 99);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    expect_wr(100, 0);
    tick();
    check("midrst_we", 32'(fb_we_o), 0);
    check("midrst_busy", 32'(busy_o), 0);
    check("midrst_ready", 32'(ready_o), 1);
    check("midrst_drop", 32'(drop_cnt_o), 0);
    exp_q.delete();
    reset = 1'b1;
    idle(5);
    set_pix(7, 7, 4);
    expect_wr(1127, 4);
    tick();
    idle(5);
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
